// File: rtl/instr_fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch unit.
// FETCH_MISALIGN_CHECK_EN adds the MISALIGN state encoding.
package instr_fetch_unit_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam logic [1:0] ST_BOOT     = 2'd0;
    localparam logic [1:0] ST_RUN      = 2'd1;
`ifdef FETCH_MISALIGN_CHECK_EN
    localparam logic [1:0] ST_MISALIGN = 2'd2;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_fifo.sv
// Single-clock instruction queue of {pc, instr} entries with flush.
module fetch_fifo
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic                           pop,
    input  logic                           flush,
    input  fetch_entry_t                   wr_data,
    output fetch_entry_t                   rd_data,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: credit-limited fetch, response queue, redirect flush.
// Define FETCH_MISALIGN_CHECK_EN to trap misaligned redirect targets.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned FQ_DEPTH = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    output logic        imem_req_out,
    output logic [31:0] imem_addr_out,
    input  logic        imem_gnt_in,
    input  logic        imem_rvalid_in,
    input  logic [31:0] imem_rdata_in,
    input  logic        redirect_in,
    input  logic [31:0] redirect_pc_in,
    input  logic        stall_in,
    output logic        instr_valid_out,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc_out
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic        misaligned_out
`endif
);
    localparam int unsigned CW        = $clog2(FQ_DEPTH + 1);
    localparam logic [CW:0] DEPTH_LIM = (CW+1)'(FQ_DEPTH);

    logic [1:0]    state;
    logic [31:0]   fetch_pc;
    logic [31:0]   rsp_pc;
    logic [31:0]   target_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic [CW-1:0] q_count;
    logic [CW:0]   credit_used;
    logic          q_full;
    logic          q_empty;
    logic          grant;
    logic          rsp;
    logic          push;
    logic          pop;
    fetch_entry_t  q_head;
    fetch_entry_t  q_wdata;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic [31:0] bad_pc;
    logic        tgt_misaligned;
    assign target_pc      = redirect_pc_in;
    assign tgt_misaligned = (redirect_pc_in[1:0] != 2'b00);
    assign misaligned_out = (state == ST_MISALIGN);
`else
    logic unused_pc_bits;
    assign unused_pc_bits = ^redirect_pc_in[1:0];
    assign target_pc      = {redirect_pc_in[31:2], 2'b00};
`endif

    // Credit uses registered counts only, so a same-cycle pop frees space next cycle.
    assign credit_used     = {1'b0, outstanding} + {1'b0, q_count};
    assign imem_req_out    = (state == ST_RUN) && !redirect_in && (credit_used < DEPTH_LIM);
    assign imem_addr_out   = fetch_pc;
    assign grant           = imem_req_out & imem_gnt_in;
    assign rsp             = imem_rvalid_in && (state != ST_BOOT);
    assign push            = rsp && (discard == '0) && !redirect_in && !q_full;
    assign instr_valid_out = !q_empty && !redirect_in;
    assign pop             = instr_valid_out && !stall_in;
    assign q_wdata         = {rsp_pc, imem_rdata_in};

    always_comb begin
        instr_out    = NOP_INSTR;
        instr_pc_out = '0;
        if (!q_empty) begin
            instr_out    = q_head.instr;
            instr_pc_out = q_head.pc;
        end
`ifdef FETCH_MISALIGN_CHECK_EN
        if (state == ST_MISALIGN) instr_pc_out = bad_pc;
`endif
    end

    // rsp_pc tracks the address of the next response that will be kept.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding + CW'(grant) - CW'(rsp);
            if (redirect_in) begin
                fetch_pc <= target_pc;
                rsp_pc   <= target_pc;
                discard  <= outstanding - CW'(rsp);
            end else begin
                if (grant) fetch_pc <= pc_inc(fetch_pc);
                if (push)  rsp_pc   <= pc_inc(rsp_pc);
                if (rsp && discard != '0) discard <= discard - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= ST_BOOT;
        end else begin
            case (state)
`ifdef FETCH_MISALIGN_CHECK_EN
                ST_BOOT:     state <= (redirect_in && tgt_misaligned) ? ST_MISALIGN : ST_RUN;
                ST_RUN:      if (redirect_in && tgt_misaligned) state <= ST_MISALIGN;
                ST_MISALIGN: if (redirect_in && !tgt_misaligned) state <= ST_RUN;
`else
                ST_BOOT:     state <= ST_RUN;
                ST_RUN:      state <= ST_RUN;
`endif
                default:     state <= ST_BOOT;
            endcase
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            bad_pc <= '0;
        end else if (redirect_in && tgt_misaligned) begin
            bad_pc <= redirect_pc_in;
        end
    end
`endif

    fetch_fifo #(
        .DEPTH (FQ_DEPTH)
    ) u_fifo (
        .clk     (clk_in),
        .rst     (rst_in),
        .push    (push),
        .pop     (pop),
        .flush   (redirect_in),
        .wr_data (q_wdata),
        .rd_data (q_head),
        .full    (q_full),
        .empty   (q_empty),
        .count   (q_count)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit with a random-latency memory model.
// Build with +define+FETCH_MISALIGN_CHECK_EN to also cover misaligned redirects.
`timescale 1ns/1ps
module tb_instr_fetch_unit;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam int          DEPTH  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req, gnt = 1'b0, rvalid = 1'b0, redirect = 1'b0, stall = 1'b0, ivalid;
    logic [31:0] addr, rdata = '0, redirect_pc = '0, instr, ipc;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        misaligned;
`endif

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_pop = 0;
    int unsigned cyc = 0;
    int unsigned tb_out = 0;
    int unsigned gnt_pct = 100, lat_min = 1, lat_max = 1;

    logic [31:0] exp_pc_q[$];
    logic [31:0] exp_tail;
    logic [31:0] exp_addr;
    bit          model_halted = 1'b0;
    logic [31:0] pend_addr[$];
    int unsigned pend_due[$];

    instr_fetch_unit #(
        .RESET_PC (RST_PC),
        .FQ_DEPTH (DEPTH)
    ) dut (
        .clk_in          (clk),
        .rst_in          (rst),
        .imem_req_out    (req),
        .imem_addr_out   (addr),
        .imem_gnt_in     (gnt),
        .imem_rvalid_in  (rvalid),
        .imem_rdata_in   (rdata),
        .redirect_in     (redirect),
        .redirect_pc_in  (redirect_pc),
        .stall_in        (stall),
        .instr_valid_out (ivalid),
        .instr_out       (instr),
        .instr_pc_out    (ipc)
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        .misaligned_out  (misaligned)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: after reset/redirect the decode stream is target, target+4, ...
    function automatic void model_restart(input logic [31:0] t);
        exp_pc_q.delete();
        exp_tail = t;
        for (int i = 0; i < 64; i++) begin
            exp_pc_q.push_back(exp_tail);
            exp_tail += 32'd4;
        end
        exp_addr     = t;
        model_halted = 1'b0;
    endfunction

    function automatic void model_redirect(input logic [31:0] t);
`ifdef FETCH_MISALIGN_CHECK_EN
        if (t[1:0] != 2'b00) begin
            exp_pc_q.delete();
            model_halted = 1'b1;
        end else begin
            model_restart(t);
        end
`else
        model_restart({t[31:2], 2'b00});
`endif
    endfunction

    // Memory: in-order responses, random latency >= 1.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (rst) begin
            gnt    = 1'b0;
            rvalid = 1'b0;
        end else begin
            gnt = ($urandom_range(99) < gnt_pct);
            if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
                rvalid = 1'b1;
                rdata  = mem_word(pend_addr[0]);
            end else begin
                rvalid = 1'b0;
                rdata  = $urandom;
            end
        end
    end

    // Monitor: observes handshakes mid-cycle and checks against the scoreboard.
    always @(negedge clk) begin
        logic [31:0] e;
        if (!rst) begin
            if (req && gnt) begin
                if (model_halted) chk("req_while_misaligned", 32'(req), 32'd0);
                else              chk("grant_addr", addr, exp_addr);
                exp_addr += 32'd4;
                pend_addr.push_back(addr);
                pend_due.push_back(cyc + $urandom_range(lat_max, lat_min));
                tb_out++;
                chk("outstanding_bound", 32'(tb_out <= DEPTH), 32'd1);
            end
            if (rvalid && pend_addr.size() > 0) begin
                void'(pend_addr.pop_front());
                void'(pend_due.pop_front());
                tb_out--;
            end
            if (ivalid && !stall) begin
                n_pop++;
                if (exp_pc_q.size() == 0) begin
                    chk("unexpected_delivery", ipc, 32'hDEAD_BEEF);
                end else begin
                    e = exp_pc_q.pop_front();
                    chk("instr_pc", ipc, e);
                    chk("instr_word", instr, mem_word(e));
                    exp_pc_q.push_back(exp_tail);
                    exp_tail += 32'd4;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #3;
        rst      = 1'b1;
        redirect = 1'b0;
        stall    = 1'b0;
        pend_addr.delete();
        pend_due.delete();
        tb_out   = 0;
        #1;
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_addr", addr, RST_PC);
        chk("rst_valid", 32'(ivalid), 32'd0);
        chk("rst_instr", instr, NOP);
        chk("rst_pc", ipc, 32'd0);
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("rst_misaligned", 32'(misaligned), 32'd0);
`endif
        step();
        step();
        model_restart(RST_PC);
        rst = 1'b0;
    endtask

    task automatic do_redirect(input logic [31:0] t);
        step();
        redirect    = 1'b1;
        redirect_pc = t;
        model_redirect(t);
        step();
        redirect    = 1'b0;
        redirect_pc = $urandom;
    endtask

    task automatic wait_valid(input string name, input logic [31:0] exp_pc);
        int w = 0;
        @(negedge clk);
        while (!ivalid && w < 40) begin
            w++;
            @(negedge clk);
        end
        chk({name, "_valid"}, 32'(ivalid), 32'd1);
        chk({name, "_pc"}, ipc, exp_pc);
    endtask

    initial begin
        #500_000;
        n_bad++;
        $display("FAIL watchdog: actual=timeout required=finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        logic [31:0] held_pc, held_instr, held_addr, t;
        int k;

        apply_reset();

        // Boot and first fetches: one BOOT cycle, then back-to-back addresses
        k = 0;
        @(negedge clk);
        while (!req && k < 5) begin
            k++;
            @(negedge clk);
        end
        chk("boot_cycles", 32'(k), 32'd1);
        chk("addr0", addr, RST_PC);
        chk("valid_early0", 32'(ivalid), 32'd0);
        @(negedge clk);
        chk("addr1", addr, RST_PC + 32'd4);
        chk("valid_early1", 32'(ivalid), 32'd0);
        @(negedge clk);
        chk("addr2", addr, RST_PC + 32'd8);
        chk("first_valid", 32'(ivalid), 32'd1);
        chk("first_pc", ipc, RST_PC);

        // Stall: queue fills, requests stop, head holds
        step();
        stall = 1'b1;
        @(negedge clk);
        held_pc    = ipc;
        held_instr = instr;
        chk("stall_valid", 32'(ivalid), 32'd1);
        repeat (5) begin
            @(negedge clk);
            chk("stall_pc_hold", ipc, held_pc);
            chk("stall_instr_hold", instr, held_instr);
        end
        chk("stall_full_noreq", 32'(req), 32'd0);
        step();
        stall = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("drain_valid", 32'(ivalid), 32'd1);
        end

        // Redirect with responses in flight
        lat_min = 2;
        lat_max = 2;
        repeat (4) step();
        do_redirect(32'h0000_0100);
        wait_valid("redir100", 32'h0000_0100);

        // Grant withheld for three cycles
        lat_min = 1;
        lat_max = 1;
        repeat (3) step();
        gnt_pct = 0;
        @(negedge clk);
        @(negedge clk);
        held_addr = addr;
        chk("nognt_req", 32'(req), 32'd1);
        @(negedge clk);
        chk("nognt_hold1", addr, held_addr);
        @(negedge clk);
        chk("nognt_hold2", addr, held_addr);
        gnt_pct = 100;
        @(negedge clk);
        chk("nognt_hold3", addr, held_addr);
        repeat (4) step();

`ifdef FETCH_MISALIGN_CHECK_EN
        do_redirect(32'h0000_0102);
        repeat (5) begin
            @(negedge clk);
            chk("mis_flag", 32'(misaligned), 32'd1);
            chk("mis_noreq", 32'(req), 32'd0);
            chk("mis_pc", ipc, 32'h0000_0102);
        end
        do_redirect(32'h0000_0200);
        wait_valid("mis_recover", 32'h0000_0200);
        chk("mis_cleared", 32'(misaligned), 32'd0);
`else
        do_redirect(32'h0000_0102);
        wait_valid("low_bits_forced", 32'h0000_0100);
`endif

        // Asynchronous reset in the middle of a burst
        lat_min = 1;
        lat_max = 3;
        repeat (6) step();
        apply_reset();
        wait_valid("post_reset", RST_PC);

        // Random traffic, including redirects near the address-space wrap
        gnt_pct = 75;
        for (int i = 0; i < 1500; i++) begin
            step();
            stall = ($urandom_range(99) < 25);
            if ($urandom_range(99) < 3) begin
                t = $urandom & 32'h0000_FFFC;
                if ($urandom_range(9) == 0) t = 32'hFFFF_FFE0 | ($urandom & 32'h0000_001C);
                if ($urandom_range(4) == 0) t[1:0] = 2'($urandom_range(3, 1));
                redirect    = 1'b1;
                redirect_pc = t;
                model_redirect(t);
            end else begin
                redirect    = 1'b0;
                redirect_pc = $urandom;
            end
        end
        step();
        redirect = 1'b0;
        stall    = 1'b0;
        do_redirect(32'h0000_0400);
        gnt_pct = 100;
        wait_valid("final", 32'h0000_0400);
        repeat (20) step();
        chk("deliveries_seen", 32'(n_pop > 200), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL provide parameter FQ_DEPTH, default 4, instruction-queue entries (power of two, >=2).
REQ-003 SHALL provide clk_in  input  1  sole clock, rising edge.
REQ-004 SHALL provide rst_in  input  1  reset, asynchronous, active-high.
REQ-005 SHALL provide imem_req_out  output  1  fetch request valid.
REQ-006 SHALL provide imem_addr_out  output  32  fetch address, word aligned.
REQ-007 SHALL provide imem_gnt_in  input  1  request accepted this cycle.
REQ-008 SHALL provide imem_rvalid_in  input  1  read data valid; in order, one per grant, latency >=1 cycle.
REQ-009 SHALL provide imem_rdata_in  input  32  fetched instruction word.
REQ-010 SHALL provide redirect_in  input  1  taken branch/jump, flush.
REQ-011 SHALL provide redirect_pc_in  input  32  redirect target.
REQ-012 SHALL provide stall_in  input  1  decode stage not ready.
REQ-013 SHALL provide instr_valid_out  output  1  instr_out/instr_pc_out valid to decode.
REQ-014 SHALL provide instr_out  output  32  instruction; bits [6:2], [14:12], [30] drive decoder opcode, func3, func7[5].
REQ-015 SHALL provide instr_pc_out  output  32  PC of instr_out.
REQ-016 SHALL provide misaligned_out  output  1  misaligned redirect flag (present only under REQ-036).

Function
REQ-017 SHALL implement states BOOT, RUN, MISALIGN; reset enters BOOT; BOOT -> RUN after one cycle.
REQ-018 SHALL assert imem_req_out in RUN only when outstanding + queue occupancy < FQ_DEPTH and redirect_in=0.
REQ-019 SHALL advance the fetch PC by 4 on each cycle with imem_req_out & imem_gnt_in; wrap 32'hFFFF_FFFC -> 0.
REQ-020 SHALL hold imem_addr_out stable while imem_req_out=1 and imem_gnt_in=0.
REQ-021 SHALL track outstanding (granted, not returned) requests in a counter 0..FQ_DEPTH; grant and rvalid in the same cycle leave it unchanged.
REQ-022 SHALL push {pc, imem_rdata_in} into the queue on imem_rvalid_in unless the response is marked for discard.
REQ-023 SHALL present the queue head combinationally: instr_valid_out = queue non-empty & ~redirect_in.
REQ-024 SHALL pop the head when instr_valid_out=1 and stall_in=0; hold instr_out/instr_pc_out stable while stall_in=1.
REQ-025 SHALL never overflow: the credit check of REQ-018 uses registered counts; a same-cycle pop frees credit only next cycle.
REQ-026 SHALL, on redirect_in=1: empty the queue, set fetch PC to redirect_pc_in, load discard counter with outstanding count minus any response returning that cycle, fetch from the target from the next cycle.
REQ-027 SHALL drop the next N responses while the discard counter N>0, decrementing per rvalid; new requests are permitted meanwhile.
REQ-028 SHALL give redirect priority over push, pop and grant in the same cycle.
REQ-029 SHALL ignore imem_rvalid_in in BOOT.
REQ-030 SHALL achieve one instruction per cycle at 1-cycle memory latency, FQ_DEPTH>=2, no stall.

Reset
REQ-031 SHALL on rst_in=1 immediately set: imem_req_out=0, imem_addr_out=RESET_PC, instr_valid_out=0, instr_out=32'h0000_0013 (NOP), instr_pc_out=0, misaligned_out=0.
REQ-032 SHALL on rst_in=1 clear queue, outstanding and discard counters, independent of clock.
REQ-033 SHALL, on reset asserted mid-transfer, drop all in-flight responses; fetch restarts at RESET_PC.

Configuration
REQ-034 SHALL support macro FETCH_MISALIGN_CHECK_EN.
REQ-035 SHALL, without the macro, force redirect_pc_in[1:0] to 2'b00; misaligned_out and MISALIGN state are absent.
REQ-036 SHALL, with the macro, on redirect with redirect_pc_in[1:0]!=0: flush per REQ-026, enter MISALIGN, issue no requests, set misaligned_out=1, instr_pc_out=redirect_pc_in; leave only on an aligned redirect (-> RUN) or reset.

Structure
REQ-037 SHALL place NOP_INSTR, default RESET_PC and state encodings in the shared core package/header.
REQ-038 SHALL implement the queue as sub-module fetch_fifo (synchronous, 64-bit {pc,instr} entries, full/empty flags).

Verification
REQ-039 Reset release, gnt=1, 1-cycle latency -> addresses 0x0,0x4,0x8 on consecutive cycles; instr_pc_out 0x0 two cycles after first request.
REQ-040 stall_in=1 for 6 cycles -> queue fills to 4, imem_req_out=0, instr_out stable; release -> one pop per cycle.
REQ-041 redirect_in=1, target 0x100, 2 responses in flight -> both dropped; next instr_pc_out=0x100.
REQ-042 gnt=0 for 3 cycles -> imem_addr_out held; no duplicate/lost PCs.
REQ-043 macro on, redirect to 0x102 -> misaligned_out=1, no requests; redirect to 0x200 -> RUN, fetch 0x200.
REQ-044 rst_in pulsed mid-burst (async, between edges) -> outputs reset instantly; fetch resumes at RESET_PC.
